// File: rtl/rx_iq_capture_pkg.sv
// rx_iq_capture_pkg: shared definitions for the I/Q snapshot capture block.
//   - cap_state_e : capture FSM state encoding (IDLE/ARMED/CAPTURE/DONE)
//   - DEF_DW/AW/SW: default sample, address and skip-count widths, also
//                   used by the CSR wrapper so both sides agree on layout.
package rx_iq_capture_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 10;
  localparam int DEF_SW = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/rx_iq_capture_if.sv
// rx_iq_capture_if: bundles the sample stream, control/config and readback
// signals of rx_iq_capture.
//   master : RX channel + CSR side (drives samples, control, rd_addr)
//   slave  : capture block (drives rd_data, busy, done, sample_count)
interface rx_iq_capture_if #(
  parameter int DW = 16,
  parameter int AW = 10,
  parameter int SW = 8
);
  // decimated sample stream
  logic signed [DW-1:0] in_x;
  logic signed [DW-1:0] in_y;
  logic                 in_ce;
  // control / configuration
  logic                 arm;
  logic                 abort;
  logic                 trig_en;
  logic signed [DW-1:0] trig_level;
  logic [AW-1:0]        cap_len;
  logic [SW-1:0]        skip;
  // readback / status
  logic [AW-1:0]        rd_addr;
  logic [2*DW-1:0]      rd_data;
  logic                 busy;
  logic                 done;
  logic [AW:0]          sample_count;

  modport master (
    output in_x, in_y, in_ce, arm, abort, trig_en, trig_level, cap_len, skip, rd_addr,
    input  rd_data, busy, done, sample_count
  );

  modport slave (
    input  in_x, in_y, in_ce, arm, abort, trig_en, trig_level, cap_len, skip, rd_addr,
    output rd_data, busy, done, sample_count
  );
endinterface

// File: rtl/rx_iq_capture_ram.sv
// iq_capture_ram: simple dual-port RAM, 2^AW words of W bits.
//   clk_i           : clock
//   rst_i           : async active-high reset (read register only)
//   we_i/waddr_i/wdata_i : synchronous write port
//   raddr_i/rdata_o : registered read port, one-cycle latency
// Array contents are never reset so the memory maps onto block RAM; only
// the output register is cleared.
module iq_capture_ram #(
  parameter int AW = 10,
  parameter int W  = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [0:(2**AW)-1];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // read-first: same-address read during a write returns the old word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rx_iq_capture.sv
// rx_iq_capture: on arm, stores a burst of cap_len+1 {I,Q} pairs from the
// decimated RX stream into RAM, starting immediately or on a rising
// crossing of in_x through trig_level; skip samples are dropped between
// stored ones after the first.
//   sys_clk, rst : clock, async active-high reset
//   bus (slave)  : sample stream, arm/abort, trigger/length/skip config,
//                  rd_addr -> rd_data (1-cycle), busy, done, sample_count
module rx_iq_capture
  import rx_iq_capture_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int SW = DEF_SW
) (
  input  logic           sys_clk,
  input  logic           rst,
  rx_iq_capture_if.slave bus
);

  cap_state_e           state_q, state_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [SW-1:0]        skip_q, skip_d;
  logic signed [DW-1:0] prevx_q, prevx_d;
  logic                 done_q, done_d;

  logic                 we;
  logic [AW-1:0]        waddr;
  logic                 qualify;
  logic                 skipping;
  logic                 last_wr;

  // rising crossing: previous below threshold, current at/above it
  assign qualify  = !bus.trig_en ||
                    ((prevx_q < bus.trig_level) && (bus.in_x >= bus.trig_level));
  assign skipping = (skip_q < bus.skip);
  assign last_wr  = (wptr_q == bus.cap_len);

  // state register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (bus.arm) state_d = ST_ARMED;
        ST_ARMED:
          if (bus.in_ce && qualify)
            state_d = (bus.cap_len == '0) ? ST_DONE : ST_CAPTURE;
        ST_CAPTURE:
          if (bus.in_ce && !skipping && last_wr) state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // outputs and datapath next values
  always_comb begin
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    prevx_d = prevx_q;
    done_d  = done_q;
    we      = 1'b0;
    waddr   = wptr_q;
    if (bus.abort) begin
      done_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE:
          if (bus.arm) begin
            done_d  = 1'b0;
            cnt_d   = '0;
            wptr_d  = '0;
            skip_d  = '0;
            // seeding with the threshold blocks a crossing on the first sample
            prevx_d = bus.trig_level;
          end
        ST_ARMED:
          if (bus.in_ce) begin
            prevx_d = bus.in_x;
            if (qualify) begin
              we     = 1'b1;
              waddr  = '0;
              cnt_d  = (AW+1)'(1);
              wptr_d = AW'(1);
              if (bus.cap_len == '0) done_d = 1'b1;
            end
          end
        ST_CAPTURE:
          if (bus.in_ce) begin
            if (skipping) begin
              skip_d = skip_q + SW'(1);
            end else begin
              we     = 1'b1;
              wptr_d = wptr_q + AW'(1);
              cnt_d  = cnt_q + (AW+1)'(1);
              skip_d = '0;
              if (last_wr) done_d = 1'b1;
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      cnt_q   <= '0;
      skip_q  <= '0;
      prevx_q <= '0;
      done_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      prevx_q <= prevx_d;
      done_q  <= done_d;
    end
  end

  iq_capture_ram #(.AW(AW), .W(2*DW)) u_ram (
    .clk_i   (sys_clk),
    .rst_i   (rst),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i ({bus.in_x, bus.in_y}),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

  assign bus.busy         = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign bus.done         = done_q;
  assign bus.sample_count = cnt_q;

endmodule

// File: tb/tb_rx_iq_capture.sv
module tb_rx_iq_capture;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int SW = 8;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  int   n_cmp   = 0;
  int   n_err   = 0;

  rx_iq_capture_if #(.DW(DW), .AW(AW), .SW(SW)) bus ();

  rx_iq_capture #(.DW(DW), .AW(AW), .SW(SW)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // expected stored word for a sample with I = x; Q is derived from x
  function automatic logic [2*DW-1:0] pair(input int x);
    logic [DW-1:0] xi;
    xi = DW'(x);
    return {xi, xi ^ 16'h5A5A};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input int x, input bit ce);
    bus.in_x  = DW'(x);
    bus.in_y  = DW'(x) ^ 16'h5A5A;
    bus.in_ce = ce;
    tick();
    bus.in_ce = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic rd(input int a, output logic [2*DW-1:0] d);
    bus.rd_addr = AW'(a);
    tick();
    d = bus.rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++;
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++;
    if (bus.sample_count !== 11'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.sample_count); end
    n_cmp++;
    if (bus.rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_immediate();
    logic [2*DW-1:0] d;
    bus.trig_en = 1'b0; bus.cap_len = 10'd7; bus.skip = 8'd0;
    pulse_arm();
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL imm_busy_armed got %b want 1", bus.busy); end
    for (int i = 0; i <= 20; i++) begin
      drive(i, 1'b1);
      drive(0, 1'b0);
    end
    n_cmp++;
    if (bus.done !== 1'b1) begin n_err++; $display("FAIL imm_done got %b want 1", bus.done); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL imm_busy got %b want 0", bus.busy); end
    n_cmp++;
    if (bus.sample_count !== 11'd8) begin n_err++; $display("FAIL imm_count got %0d want 8", bus.sample_count); end
    for (int a = 0; a < 8; a++) begin
      rd(a, d);
      n_cmp++;
      if (d !== pair(a)) begin n_err++; $display("FAIL imm_data[%0d] got %h want %h", a, d, pair(a)); end
    end
  endtask

  task automatic test_trigger();
    logic [2*DW-1:0] d;
    int xs[5] = '{150, 50, 90, 100, 120};
    bus.trig_en = 1'b1; bus.trig_level = 16'sd100; bus.cap_len = 10'd1; bus.skip = 8'd0;
    pulse_arm();
    for (int i = 0; i < 5; i++) drive(xs[i], 1'b1);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.sample_count !== 11'd2) begin
      n_err++; $display("FAIL trig_done got done=%b cnt=%0d want done=1 cnt=2", bus.done, bus.sample_count);
    end
    rd(0, d);
    n_cmp++;
    if (d !== pair(100)) begin n_err++; $display("FAIL trig_addr0 got %h want %h", d, pair(100)); end
    rd(1, d);
    n_cmp++;
    if (d !== pair(120)) begin n_err++; $display("FAIL trig_addr1 got %h want %h", d, pair(120)); end
  endtask

  // only a signed compare sees -20 -> 5 as crossing -10
  task automatic test_signed_trigger();
    logic [2*DW-1:0] d;
    bus.trig_en = 1'b1; bus.trig_level = -16'sd10; bus.cap_len = 10'd0;
    pulse_arm();
    drive(-20, 1'b1);
    drive(5, 1'b1);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.sample_count !== 11'd1) begin
      n_err++; $display("FAIL sgn_done got done=%b cnt=%0d want done=1 cnt=1", bus.done, bus.sample_count);
    end
    rd(0, d);
    n_cmp++;
    if (d !== pair(5)) begin n_err++; $display("FAIL sgn_addr0 got %h want %h", d, pair(5)); end
  endtask

  task automatic test_skip();
    logic [2*DW-1:0] d;
    bus.trig_en = 1'b0; bus.cap_len = 10'd3; bus.skip = 8'd2;
    pulse_arm();
    for (int i = 0; i < 16; i++) drive(i, 1'b1);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.sample_count !== 11'd4) begin
      n_err++; $display("FAIL skip_done got done=%b cnt=%0d want done=1 cnt=4", bus.done, bus.sample_count);
    end
    for (int a = 0; a < 4; a++) begin
      rd(a, d);
      n_cmp++;
      if (d !== pair(3 * a)) begin n_err++; $display("FAIL skip_data[%0d] got %h want %h", a, d, pair(3 * a)); end
    end
  endtask

  task automatic test_abort();
    logic [2*DW-1:0] d;
    bus.trig_en = 1'b0; bus.cap_len = 10'd7; bus.skip = 8'd0;
    pulse_arm();
    drive(40, 1'b1); drive(41, 1'b1); drive(42, 1'b1);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL abort_pre got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL abort_idle got busy=%b done=%b want busy=0 done=0", bus.busy, bus.done);
    end
    n_cmp++;
    if (bus.sample_count !== 11'd3) begin n_err++; $display("FAIL abort_count got %0d want 3", bus.sample_count); end
    // re-arm: must restart at address 0
    bus.cap_len = 10'd0;
    pulse_arm();
    drive(77, 1'b1);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.sample_count !== 11'd1) begin
      n_err++; $display("FAIL rearm_done got done=%b cnt=%0d want done=1 cnt=1", bus.done, bus.sample_count);
    end
    rd(0, d);
    n_cmp++;
    if (d !== pair(77)) begin n_err++; $display("FAIL rearm_addr0 got %h want %h", d, pair(77)); end
    rd(1, d);
    n_cmp++;
    if (d !== pair(41)) begin n_err++; $display("FAIL rearm_addr1 got %h want %h", d, pair(41)); end
  endtask

  task automatic test_arm_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.trig_en = 1'b0; bus.cap_len = 10'd7;
    bus.arm = 1'b1; bus.abort = 1'b1;
    tick();
    bus.arm = 1'b0; bus.abort = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL armabort got busy=%b done=%b want busy=0 done=0", bus.busy, bus.done);
    end
    // if it had armed, this sample would start a burst
    drive(9, 1'b1);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.sample_count !== 11'd1) begin
      n_err++; $display("FAIL armabort_idle got busy=%b cnt=%0d want busy=0 cnt=1", bus.busy, bus.sample_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] d;
    bus.trig_en = 1'b0; bus.cap_len = 10'd1023; bus.skip = 8'd0;
    pulse_arm();
    for (int i = 0; i < 1023; i++) drive(i, 1'b1);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL full_early got done=%b busy=%b want done=0 busy=1", bus.done, bus.busy);
    end
    drive(1023, 1'b1);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL full_done got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
    end
    n_cmp++;
    if (bus.sample_count !== 11'd1024) begin n_err++; $display("FAIL full_count got %0d want 1024", bus.sample_count); end
    // extra samples after done must not wrap onto address 0
    drive(2000, 1'b1); drive(2001, 1'b1);
    rd(0, d);
    n_cmp++;
    if (d !== pair(0)) begin n_err++; $display("FAIL full_nowrap got %h want %h", d, pair(0)); end
    bus.rd_addr = 10'd1023;
    #1;
    n_cmp++;
    if (bus.rd_data !== pair(0)) begin n_err++; $display("FAIL rd_latency got %h want %h", bus.rd_data, pair(0)); end
    tick();
    n_cmp++;
    if (bus.rd_data !== pair(1023)) begin n_err++; $display("FAIL rd_last got %h want %h", bus.rd_data, pair(1023)); end
  endtask

  initial begin
    bus.in_x = '0; bus.in_y = '0; bus.in_ce = 1'b0;
    bus.arm = 1'b0; bus.abort = 1'b0;
    bus.trig_en = 1'b0; bus.trig_level = '0;
    bus.cap_len = '0; bus.skip = '0; bus.rd_addr = '0;
    test_reset();
    test_immediate();
    test_trigger();
    test_signed_trigger();
    test_skip();
    test_abort();
    test_arm_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rx_iq_capture.md
# rx_iq_capture

Snapshot buffer sitting directly downstream of the RX channel: it consumes the decimated I/Q stream and its sample strobe (`ce_down`), and on software arm stores a programmable-length burst of I/Q pairs into on-chip RAM. Capture starts either immediately or on a rising threshold crossing of the I sample. The buffer is read back over a synchronous address/data port wired to LiteX CSRs, giving firmware raw baseband data for calibration and debug.

## Interface
- `DW`, 16, width of each I/Q sample (matches RX channel output width)
- `AW`, 10, buffer address width; depth = 2^AW pairs
- `SW`, 8, width of the extra-decimation (skip) count
- `sys_clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `in_x`  in  DW  signed I sample, valid when `in_ce`=1
- `in_y`  in  DW  signed Q sample, valid when `in_ce`=1
- `in_ce`  in  1  sample strobe from the RX channel decimator
- `arm`  in  1  single-cycle start request
- `abort`  in  1  single-cycle cancel request
- `trig_en`  in  1  0: immediate start; 1: threshold trigger
- `trig_level`  in  DW  signed trigger threshold on `in_x`
- `cap_len`  in  AW  number of stored pairs minus one
- `skip`  in  SW  ce samples discarded between stored samples
- `rd_addr`  in  AW  read address
- `rd_data`  out  2*DW  {I,Q} at `rd_addr`, I in upper half
- `busy`  out  1  high in ARMED or CAPTURE
- `done`  out  1  sticky burst-complete flag
- `sample_count`  out  AW+1  pairs written in the current or last burst

## Operation
- FSM: IDLE, ARMED, CAPTURE, DONE. Reset → IDLE.
- IDLE/DONE + `arm` → ARMED. In the same cycle: `done`←0, `sample_count`←0, write pointer←0, skip counter←0, previous-x register←`trig_level`. This last assignment prevents a false crossing on the first sample.
- `arm` while in ARMED or CAPTURE is ignored.
- `abort` in any state → IDLE, `done`←0. Abort wins over a simultaneous `arm`. `sample_count` holds its value.
- Trigger condition:
  - `trig_en`=0: any `in_ce` sample qualifies.
  - `trig_en`=1: a sample qualifies when prev_x < `trig_level` and `in_x` ≥ `trig_level` (signed compare).
  - prev_x updates on every `in_ce` sample while ARMED.
- ARMED + qualifying sample: write {in_x,in_y} to address 0 and set `sample_count`=1. Next state is DONE if `cap_len`=0, otherwise CAPTURE with write pointer=1.
- CAPTURE, per `in_ce` sample:
  - If skip counter < `skip`: increment the skip counter and discard the sample.
  - Otherwise: write the sample at the write pointer, increment the pointer and `sample_count`, and clear the skip counter.
  - When the written address equals `cap_len` → DONE, `done`←1.
- Skip does not apply in ARMED; every sample is evaluated for the trigger.
- `trig_en`, `trig_level`, `cap_len` and `skip` must be stable while `busy`=1. Changing them mid-burst gives defined but unspecified sample selection.
- Write pointer never wraps. The maximum burst is 2^AW pairs (`cap_len`=all ones), after which `sample_count`=2^AW.
- Read port is independent of the FSM. Reads during a capture return current RAM contents (old or new data per address).
- RAM contents are not reset.

## Timing
- Reset values: `busy`=0, `done`=0, `sample_count`=0, `rd_data`=0.
- `busy` and `done` are registered. They change one cycle after the causing `arm`, `abort` or final-write edge.
- Sample writes happen on the `in_ce` clock edge, with no pipeline delay.
- `rd_data` has one-cycle read latency: the address presented at edge N produces data valid after edge N+1.
- Back-to-back `in_ce` (every cycle) is supported at full rate.
- `rst` mid-burst returns to IDLE immediately. The buffer keeps partial data.

## Structure
- Shared package (uberclock pkg): FSM state encoding for IDLE/ARMED/CAPTURE/DONE, and default `DW`/`AW` constants shared with the CSR wrapper.
- One sub-module, `iq_capture_ram`: simple dual-port RAM of 2^AW × 2*DW with a synchronous write port and a registered read port, inferred as block RAM.
- The FSM, trigger compare, skip counter and pointers live in the top module.

## Test plan
1. `trig_en`=0, `cap_len`=7, `skip`=0, ramp x=0..20 on every other cycle, `arm` pulse. Expected: the 8 samples x=0..7 are stored at addresses 0..7, `done`=1, `sample_count`=8, `busy`=0.
2. `trig_en`=1, `trig_level`=100, x sequence 150,50,90,100,120. Expected: x=100 is stored at address 0; the first sample (150) does not trigger.
3. `skip`=2, `cap_len`=3, ramp x=0,1,2,… Expected: stored x=0,3,6,9.
4. `abort` during CAPTURE after 3 writes. Expected: IDLE the next cycle, `done`=0, `sample_count`=3; a fresh `arm` restarts from address 0.
5. `arm` and `abort` in the same cycle in IDLE. Expected: state stays IDLE, `busy`=0.
6. `cap_len`=1023 with continuous `in_ce`. Expected: `done` after 1024 writes, `sample_count`=1024, no wrap. A readback of address 1023 has 1-cycle latency and returns the last sample.
